// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: takes a length-prefixed byte stream and writes 32-bit words from address 0.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int WORD_SIZE        = 16,
  parameter int INSTRUCTION_SIZE = 32,
  parameter int DEPTH            = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        byte_valid,
  input  logic [7:0]                  byte_data,
  output logic                        byte_ready,
  output logic                        imem_we,
  output logic [WORD_SIZE-1:0]        imem_addr,
  output logic [INSTRUCTION_SIZE-1:0] imem_wdata,
  output logic                        cpu_hold,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [WORD_SIZE-1:0]        word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = S_CHK;
`else
  localparam state_t END_STATE = S_DONE;
`endif

  localparam logic [WORD_SIZE-1:0] DEPTH_W = WORD_SIZE'(DEPTH);

  state_t                        state_q, state_d;
  logic [WORD_SIZE-1:0]          len_q;
  logic [WORD_SIZE-1:0]          len_next;
  logic [WORD_SIZE-1:0]          wc_inc;
  logic [INSTRUCTION_SIZE-9:0]   asm_q;
  logic [1:0]                    byte_idx_q;
  logic                          xfer;
  logic                          start_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]                    csum_q;
`endif

  assign byte_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
`ifdef IMEM_LOADER_CHECKSUM_EN
                      (state_q == S_CHK) ||
`endif
                      (state_q == S_DATA);
  assign xfer      = byte_valid && byte_ready;
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign busy      = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign imem_we   = (state_q == S_WRITE);
  assign len_next  = {len_q[WORD_SIZE-9:0], byte_data};
  assign wc_inc    = word_count + WORD_SIZE'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN_HI;
      S_LEN_HI: if (xfer) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (len_next > DEPTH_W)              state_d = S_ERR;
          else if (len_next == '0)             state_d = END_STATE;
          else                                 state_d = S_DATA;
        end
      end
      S_DATA:   if (xfer && (byte_idx_q == 2'd3)) state_d = S_WRITE;
      S_WRITE:  state_d = (wc_inc == len_q) ? END_STATE : S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:    if (xfer) state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q      <= '0;
      asm_q      <= '0;
      byte_idx_q <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_hold   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      if (start_ok) begin
        len_q      <= '0;
        byte_idx_q <= '0;
        word_count <= '0;
        done       <= 1'b0;
        error      <= 1'b0;
        cpu_hold   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q     <= '0;
`endif
      end

      if (xfer && ((state_q == S_LEN_HI) || (state_q == S_LEN_LO)))
        len_q <= len_next;

      if (xfer && (state_q == S_DATA)) begin
        byte_idx_q <= byte_idx_q + 2'd1;
        asm_q      <= {asm_q[INSTRUCTION_SIZE-17:0], byte_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q     <= csum_q ^ byte_data;
`endif
        // Latch the word and its address as the 4th byte lands; they hold until the next word.
        if (byte_idx_q == 2'd3) begin
          imem_wdata <= {asm_q, byte_data};
          imem_addr  <= word_count;
        end
      end

      if (state_q == S_WRITE)
        word_count <= wc_inc;

      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
        done     <= 1'b1;
        cpu_hold <= 1'b0;
      end
      if ((state_d == S_ERR) && (state_q != S_ERR)) begin
        error    <= 1'b1;
        cpu_hold <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random loads compared against a word-list model of the stream.
// Honours IMEM_LOADER_CHECKSUM_EN the same way the design does.
module tb_imem_loader;
  localparam int WS    = 16;
  localparam int IS    = 32;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready, imem_we, cpu_hold, busy, done, error;
  logic [WS-1:0] imem_addr, word_count;
  logic [IS-1:0] imem_wdata;

  int total = 0;
  int bad   = 0;

  logic [7:0]       pl_q[$];
  logic [WS+IS-1:0] wr_q[$];
  logic             we_prev = 1'b0;

  imem_loader #(.WORD_SIZE(WS), .INSTRUCTION_SIZE(IS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor: records every strobe and checks it is a lone cycle with the byte port closed.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_q.push_back({imem_addr, imem_wdata});
      check("we_ready_low", 32'(byte_ready), 32'd0);
      check("we_single", 32'(we_prev), 32'd0);
    end
    we_prev = imem_we;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int idle;
    int k;
    idle = (gap == 1) ? 1 : (gap == 2) ? $urandom_range(2, 0) : 0;
    repeat (idle) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_data  = b;
    k = 0;
    @(negedge clk);
    while (!byte_ready && k < 50) begin k++; @(negedge clk); end
    if (!byte_ready) check("ready_timeout", 32'(byte_ready), 32'd1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  // Start pulse with a byte offered at the same time; that byte must not be taken.
  task automatic pulse_start();
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    start      = 1'b1;
    @(negedge clk);
    check("start_ready", 32'(byte_ready), 32'd0);
    @(posedge clk); #1;
    start      = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic do_load(input int n, input int gap, input bit corrupt, input bit mid_start, input string tag);
    logic [15:0] nl;
    logic [7:0]  x;
    logic [31:0] w;
    bit          exp_err;
    int          exp_n;
    int          k;
    nl = 16'(n);
    x  = 8'h00;
    foreach (pl_q[i]) x ^= pl_q[i];
    exp_err = (n > DEPTH);
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_err = exp_err || corrupt;
`endif
    exp_n = (n > DEPTH) ? 0 : n;
    wr_q.delete();
    pulse_start();
    check({tag, "_hold_on"}, 32'(cpu_hold), 32'd1);
    check({tag, "_busy_on"}, 32'(busy), 32'd1);
    send_byte(nl[15:8], gap);
    send_byte(nl[7:0], gap);
    if (n <= DEPTH) begin
      for (int i = 0; i < n * 4; i++) begin
        send_byte(pl_q[i], gap);
        if (mid_start && i == 0) begin
          start = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
          check({tag, "_busy_start"}, 32'(busy), 32'd1);
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(corrupt ? ~x : x, gap);
`endif
    end
    k = 0;
    @(negedge clk);
    while (!(done || error) && k < 40) begin k++; @(negedge clk); end
    check({tag, "_done"}, 32'(done), 32'(!exp_err));
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_hold_off"}, 32'(cpu_hold), 32'd0);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_ready_off"}, 32'(byte_ready), 32'd0);
    check({tag, "_wcount"}, 32'(word_count), 32'(exp_n));
    check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < wr_q.size(); i++) begin
      w = {pl_q[4*i], pl_q[4*i+1], pl_q[4*i+2], pl_q[4*i+3]};
      check({tag, "_addr"}, 32'(wr_q[i][WS+IS-1:IS]), 32'(i));
      check({tag, "_data"}, wr_q[i][IS-1:0], w);
    end
    @(posedge clk); #1;
  endtask

  task automatic set_nominal();
    pl_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  endtask

  task automatic set_random(input int n);
    pl_q.delete();
    for (int i = 0; i < n * 4; i++) pl_q.push_back(8'($urandom));
  endtask

  initial begin
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_wcount", 32'(word_count), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    set_nominal();
    do_load(2, 0, 1'b0, 1'b0, "nominal");
    do_load(2, 1, 1'b0, 1'b1, "gaps");

    pl_q.delete();
    do_load(DEPTH + 1, 0, 1'b0, 1'b0, "oversize");
    do_load(0, 0, 1'b0, 1'b0, "zero");

`ifdef IMEM_LOADER_CHECKSUM_EN
    pl_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_load(1, 0, 1'b1, 1'b0, "csum_bad");
`endif

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(12, 1);
      set_random(n);
      do_load(n, 2, 1'b0, 1'b0, "random");
    end

    set_random(DEPTH);
    do_load(DEPTH, 0, 1'b0, 1'b0, "full");

    // Reset after two payload bytes, then a clean reload.
    set_nominal();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    #2 reset = 1'b1;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_hold", 32'(cpu_hold), 32'd0);
    check("mid_ready", 32'(byte_ready), 32'd0);
    check("mid_we", 32'(imem_we), 32'd0);
    check("mid_wcount", 32'(word_count), 32'd0);
    check("mid_addr", 32'(imem_addr), 32'd0);
    check("mid_wdata", imem_wdata, 32'd0);
    check("mid_done", 32'(done), 32'd0);
    #5 reset = 1'b0;
    @(posedge clk); #1;
    do_load(2, 0, 1'b0, 1'b0, "reload");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
